// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for the sequential ALU.
//   cmd_e   - command encoding on the command port (NOP..MOD; 6-15 illegal)
//   err_e   - 2-bit error code reported with every result
//   state_e - control FSM states
//   ovf_detect - two's-complement overflow of an addition
package seq_alu_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_MUL = 4'd3,
        CMD_DIV = 4'd4,
        CMD_MOD = 4'd5
    } cmd_e;

    typedef enum logic [1:0] {
        ERR_OK  = 2'b00,
        ERR_OVF = 2'b01,
        ERR_DBZ = 2'b10,
        ERR_ILL = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Overflow of a + b_eff: both addends share a sign and the sum does not.
    // For subtraction pass the inverted MSB of the subtrahend as b_msb.
    // This equals carry-into-MSB xor carry-out.
    function automatic logic ovf_detect(input logic a_msb,
                                        input logic b_msb,
                                        input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/seq_alu_divider.sv
// seq_alu_divider: iterative unsigned restoring divider, one step per clock.
// Ports:
//   clk, rst          - clock, synchronous active-high reset (aborts a division)
//   start_i           - load operands and begin; only pulsed while idle
//   dividend_i        - WIDTH-bit dividend
//   divisor_i         - WIDTH-bit divisor, must be non-zero
//   done_o            - high in the cycle whose rising edge performs the last
//                       step; quotient_o/remainder_o are final from the next cycle
//   quotient_o        - WIDTH-bit quotient
//   remainder_o       - WIDTH-bit remainder
module seq_alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    // The dividend is shifted out of quo_q MSB-first while quotient bits
    // enter at the LSB. rem_q < divisor always holds, so rem_shift fits in
    // WIDTH+1 bits and the trial MSB is set exactly when rem_shift < divisor.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            rem_q <= trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done_o      = busy_q && (cnt_q == CNT_LAST);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/busy/done handshake, one op in flight.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (aborts an op)
//   start           - request, sampled only while busy=0
//   command         - 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 MOD, others illegal
//   inputA, inputB  - WIDTH-bit operands, latched when the request is accepted
//   busy            - operation in flight
//   done            - one-cycle pulse; result/error valid from this cycle
//   result          - 2*WIDTH-bit result, held until the next done
//   error           - 00 ok, 01 signed overflow, 10 divide by zero, 11 illegal
//
// state     | meaning
// ST_IDLE   | waiting for start; a request is accepted here
// ST_EXEC   | WIDTH iterations of shift-add multiply or restoring divide
// ST_FINISH | result/error and done are registered at the end of this cycle
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CMD_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CMD_W-1:0]     command,
    input  logic [WIDTH-1:0]     inputA,
    input  logic [WIDTH-1:0]     inputB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           error
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CMD_W-1:0] C_NOP = CMD_W'(CMD_NOP);
    localparam logic [CMD_W-1:0] C_ADD = CMD_W'(CMD_ADD);
    localparam logic [CMD_W-1:0] C_SUB = CMD_W'(CMD_SUB);
    localparam logic [CMD_W-1:0] C_MUL = CMD_W'(CMD_MUL);
    localparam logic [CMD_W-1:0] C_DIV = CMD_W'(CMD_DIV);
    localparam logic [CMD_W-1:0] C_MOD = CMD_W'(CMD_MOD);

    state_e             state_q, state_d;
    logic [CMD_W-1:0]   cmd_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               done_q;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [1:0]         error_q, error_d;
    logic               done_d;

    logic               accept;
    logic               div_start;
    logic               div_done;
    logic [WIDTH-1:0]   quotient, remainder;
    logic [WIDTH-1:0]   sum, diff;

    assign accept    = (state_q == ST_IDLE) && start && (command != C_NOP);
    // A zero divisor never starts the divider; it finishes in one cycle.
    assign div_start = accept && ((command == C_DIV) || (command == C_MOD))
                       && (inputB != '0);

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

    seq_alu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .dividend_i  (inputA),
        .divisor_i   (inputB),
        .done_o      (div_done),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if ((command == C_MUL) || div_start) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_EXEC: begin
                if ((cmd_q == C_MUL) ? (cnt_q == CNT_LAST) : div_done) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        done_d   = (state_q == ST_FINISH);
        result_d = '0;
        error_d  = ERR_OK;
        case (cmd_q)
            C_ADD: begin
                result_d[WIDTH-1:0] = sum;
                if (ovf_detect(a_q[WIDTH-1], b_q[WIDTH-1], sum[WIDTH-1])) begin
                    error_d = ERR_OVF;
                end
            end
            C_SUB: begin
                result_d[WIDTH-1:0] = diff;
                if (ovf_detect(a_q[WIDTH-1], ~b_q[WIDTH-1], diff[WIDTH-1])) begin
                    error_d = ERR_OVF;
                end
            end
            C_MUL: result_d = acc_q;
            C_DIV: begin
                if (b_q == '0) begin
                    error_d = ERR_DBZ;
                end else begin
                    result_d[WIDTH-1:0] = quotient;
                end
            end
            C_MOD: begin
                if (b_q == '0) begin
                    error_d = ERR_DBZ;
                end else begin
                    result_d[WIDTH-1:0] = remainder;
                end
            end
            default: error_d = ERR_ILL;
        endcase
    end

    // Operand latch, iteration counter and shift-add multiplier datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (accept) begin
            cmd_q    <= command;
            a_q      <= inputA;
            b_q      <= inputB;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, inputA};
            mplier_q <= inputB;
        end else if (state_q == ST_EXEC) begin
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (cmd_q == C_MUL) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q   <= 1'b0;
            result_q <= '0;
            error_q  <= ERR_OK;
        end else begin
            done_q <= done_d;
            if (done_d) begin
                result_q <= result_d;
                error_q  <= error_d;
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign error  = error_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [3:0]     command;
    logic [W-1:0]   inputA;
    logic [W-1:0]   inputB;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic [1:0]     error;

    seq_alu #(.WIDTH(W), .CMD_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .command (command),
        .inputA  (inputA),
        .inputB  (inputB),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .error   (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string          tag;
        logic [2*W-1:0] res;
        logic [1:0]     err;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t0 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2*W-1:0] r, input logic [1:0] e, input int lat);
        exp_t x;
        x.tag = tag;
        x.res = r;
        x.err = e;
        x.lat = lat;
        sb.push_back(x);
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge with
    // the operand inputs scrambled so latching is exercised.
    task automatic launch(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        command = c;
        inputA  = a;
        inputB  = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        t0      = cyc;
        start   = 1'b0;
        inputA  = W'($urandom);
        inputB  = W'($urandom);
        command = 4'($urandom);
    endtask

    task automatic finish_op();
        exp_t x;
        bit   busy_ok = 1'b1;
        int   n = 0;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty_at_done", 64'(sb.size()), 64'd1);
        end else begin
            x = sb.pop_front();
            check({x.tag, "/done_seen"}, 64'(done), 64'd1);
            check({x.tag, "/result"}, 64'(result), 64'(x.res));
            check({x.tag, "/error"}, 64'(error), 64'(x.err));
            check({x.tag, "/latency"}, 64'(cyc - t0), 64'(x.lat));
            check({x.tag, "/busy_throughout"}, 64'(busy_ok), 64'd1);
            check({x.tag, "/busy_at_done"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic idle_check(input string tag, input int n, input logic [2*W-1:0] hold_res);
        int pulses = 0;
        bit busy_seen = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
            if (busy) busy_seen = 1'b1;
        end
        check({tag, "/done_pulses"}, 64'(pulses), 64'd0);
        check({tag, "/busy_idle"}, 64'(busy_seen), 64'd0);
        check({tag, "/result_hold"}, 64'(result), 64'(hold_res));
    endtask

    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [2*W-1:0] r, output logic [1:0] e, output int lat);
        logic [W-1:0] t;
        r   = '0;
        e   = 2'b00;
        lat = 1;
        case (c)
            4'd1: begin
                t = a + b;
                r = {{W{1'b0}}, t};
                if (a[W-1] == b[W-1] && t[W-1] != a[W-1]) e = 2'b01;
            end
            4'd2: begin
                t = a - b;
                r = {{W{1'b0}}, t};
                if (a[W-1] != b[W-1] && t[W-1] != a[W-1]) e = 2'b01;
            end
            4'd3: begin
                r   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                lat = W + 1;
            end
            4'd4: begin
                if (b == '0) e = 2'b10;
                else begin r = {{W{1'b0}}, a / b}; lat = W + 1; end
            end
            4'd5: begin
                if (b == '0) e = 2'b10;
                else begin r = {{W{1'b0}}, a % b}; lat = W + 1; end
            end
            default: e = 2'b11;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] mr;
        logic [1:0]     me;
        int             ml;
        logic [3:0]     rc;
        logic [W-1:0]   ra, rb;

        rst     = 1'b1;
        start   = 1'b0;
        command = 4'd0;
        inputA  = '0;
        inputB  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/result", 64'(result), 64'd0);
        check("reset/error", 64'(error), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        push("add_249_69", 32'd318, 2'b00, 1);       launch(4'd1, 16'd249, 16'd69); finish_op();
        push("sub_249_69", 32'd180, 2'b00, 1);       launch(4'd2, 16'd249, 16'd69); finish_op();
        push("mul_249_69", 32'd17181, 2'b00, 17);    launch(4'd3, 16'd249, 16'd69); finish_op();
        push("div_249_69", 32'd3, 2'b00, 17);        launch(4'd4, 16'd249, 16'd69); finish_op();
        push("mod_249_69", 32'd42, 2'b00, 17);       launch(4'd5, 16'd249, 16'd69); finish_op();
        push("add_ovf", 32'h0000BB81, 2'b01, 1);     launch(4'd1, 16'h7D00, 16'h3E81); finish_op();
        push("mul_big", 32'd512032000, 2'b00, 17);   launch(4'd3, 16'h7D00, 16'h3E81); finish_op();
        push("sub_ovf", 32'h00007FFF, 2'b01, 1);     launch(4'd2, 16'h8000, 16'h0001); finish_op();
        push("add_wrap_no_ovf", 32'd0, 2'b00, 1);    launch(4'd1, 16'hFFFF, 16'h0001); finish_op();
        push("mul_max", 32'hFFFE0001, 2'b00, 17);    launch(4'd3, 16'hFFFF, 16'hFFFF); finish_op();
        push("div_by_one", 32'h0000FFFF, 2'b00, 17); launch(4'd4, 16'hFFFF, 16'h0001); finish_op();
        push("mod_a_lt_b", 32'd7, 2'b00, 17);        launch(4'd5, 16'd7, 16'd9); finish_op();
        push("div_by_zero", 32'd0, 2'b10, 1);        launch(4'd4, 16'd249, 16'd0); finish_op();
        push("mod_by_zero", 32'd0, 2'b10, 1);        launch(4'd5, 16'd1234, 16'd0); finish_op();
        push("illegal_7", 32'd0, 2'b11, 1);          launch(4'd7, 16'd249, 16'd69); finish_op();

        // NOP with start in the done cycle: no operation, previous result held.
        command = 4'd0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("nop/done_after_pulse", 64'(done), 64'd0);
        idle_check("nop", 4, 32'd0);

        // A second start in the middle of a MUL is ignored and not queued.
        push("mul_mid_start", 32'd17181, 2'b00, 17);
        launch(4'd3, 16'd249, 16'd69);
        repeat (3) begin @(posedge clk); #1; end
        command = 4'd1;
        inputA  = 16'd1000;
        inputB  = 16'd1000;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_op();
        idle_check("mul_mid_start_after", 4, 32'd17181);

        // Reset during cycle 5 of a DIV aborts it with no done pulse.
        launch(4'd4, 16'd1000, 16'd7);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/done", 64'(done), 64'd0);
        check("abort/result", 64'(result), 64'd0);
        check("abort/error", 64'(error), 64'd0);
        rst = 1'b0;
        idle_check("abort_after", W + 4, 32'd0);

        // Back-to-back: SUB accepted in the done cycle of a MOD.
        push("b2b_mod", 32'd6, 2'b00, 17);
        push("b2b_sub", 32'h0000FFFE, 2'b00, 1);
        launch(4'd5, 16'd1000, 16'd7);
        finish_op();
        launch(4'd2, 16'd5, 16'd7);
        finish_op();

        for (int i = 0; i < 10; i++) begin
            rc = 4'($urandom_range(1, 5));
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 2 == 1) rb = rb >> 9;
            model(rc, ra, rb, mr, me, ml);
            push($sformatf("rand%0d_cmd%0d", i, rc), mr, me, ml);
            launch(rc, ra, rb);
            finish_op();
        end

        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
